// File: rtl/accum_datapath_pkg.sv
// Shared opcode types for the teaching CPU: ALU functions and PC source select.
package opcodes;
  typedef enum logic [2:0] {
    AluPassA, AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNot, AluPassB
  } alu_functions_t;

  // Encodings 6 and 7 are unused and fall back to increment in the datapath.
  typedef enum logic [2:0] {
    PcInc  = 3'd0,
    PcJmp  = 3'd1,
    PcBrz  = 3'd2,
    PcBrn  = 3'd3,
    PcCall = 3'd4,
    PcRet  = 3'd5
  } PcSel_t;
endpackage

// File: rtl/accum_datapath_if.sv
// Control/data bundle between the control FSM + program memory and the datapath.
interface accum_datapath_if #(
  parameter int n           = 8,
  parameter int pc_n        = 5,
  parameter int stack_depth = 4
);
  import opcodes::*;
  localparam int DW = $clog2(stack_depth + 1);

  logic [n-1:0]    MemData, Switches;
  logic            RegWe, ImmSel, WDataSel, AccStore, Op1Sel, PcWe, FlagWe;
  alu_functions_t  AluOp;
  PcSel_t          PcSel;
  logic [pc_n-1:0] Pc;
  logic [n-1:0]    LEDs;
  logic            FlagZ, FlagN, StackOvf, StackUnf;
  logic [DW-1:0]   StackDepth;

  modport master (
    output MemData, Switches, RegWe, ImmSel, WDataSel, AccStore, Op1Sel, PcWe,
           FlagWe, AluOp, PcSel,
    input  Pc, LEDs, FlagZ, FlagN, StackDepth, StackOvf, StackUnf
  );
  modport slave (
    input  MemData, Switches, RegWe, ImmSel, WDataSel, AccStore, Op1Sel, PcWe,
           FlagWe, AluOp, PcSel,
    output Pc, LEDs, FlagZ, FlagN, StackDepth, StackOvf, StackUnf
  );
endinterface

// File: rtl/accum_datapath_alu.sv
// Combinational ALU; b is always the accumulator, so Sub means Acc - a.
module alu
  import opcodes::*;
#(
  parameter int n = 8
) (
  input  alu_functions_t AluOp,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic [n-1:0]   y
);
  always_comb begin
    y = a;
    case (AluOp)
      AluPassA: y = a;
      AluAdd:   y = b + a;
      AluSub:   y = b - a;
      AluAnd:   y = b & a;
      AluOr:    y = b | a;
      AluXor:   y = b ^ a;
      AluNot:   y = ~b;
      AluPassB: y = b;
      default:  y = a;
    endcase
  end
endmodule

// File: rtl/accum_datapath_registers.sv
// Register file: combinational read, write on rising edge, contents not reset.
module registers #(
  parameter int n        = 8,
  parameter int regcount = 11
) (
  input  logic         Clock,
  input  logic         We,
  input  logic [3:0]   Addr,
  input  logic [n-1:0] WData,
  output logic [n-1:0] RData
);
  logic [n-1:0] r_mem [16];

  // Full 16-entry decode keeps indexing width-clean; entries past regcount are dead.
  always_ff @(posedge Clock)
    if (We && (int'(Addr) < regcount)) r_mem[Addr] <= WData;

  assign RData = (int'(Addr) < regcount) ? r_mem[Addr] : '0;
endmodule

// File: rtl/accum_datapath_return_stack.sv
// LIFO of return addresses; caller guarantees Push only when !Full, Pop only when !Empty.
module return_stack #(
  parameter int pc_n        = 5,
  parameter int stack_depth = 4,
  localparam int DW         = $clog2(stack_depth + 1)
) (
  input  logic            Clock,
  input  logic            nReset,
  input  logic            Push,
  input  logic            Pop,
  input  logic [pc_n-1:0] PushData,
  output logic [pc_n-1:0] Top,
  output logic            Full,
  output logic            Empty,
  output logic [DW-1:0]   Depth
);
  logic [pc_n-1:0] r_mem [stack_depth];
  logic [DW-1:0]   r_depth;

  assign Full  = (int'(r_depth) == stack_depth);
  assign Empty = (r_depth == '0);
  assign Depth = r_depth;

  always_ff @(posedge Clock or negedge nReset)
    if (!nReset)               r_depth <= '0;
    else if (Push && !Full)    r_depth <= r_depth + DW'(1);
    else if (Pop && !Empty)    r_depth <= r_depth - DW'(1);

  always_ff @(posedge Clock)
    if (Push && !Full) r_mem[int'(r_depth)] <= PushData;

  assign Top = Empty ? '0 : r_mem[int'(r_depth) - 1];
endmodule

// File: rtl/accum_datapath.sv
// Accumulator datapath: operand select, Acc, register file, ALU, flags, PC with
// conditional branches and call/return through a hardware return stack.
module accum_datapath
  import opcodes::*;
#(
  parameter int n           = 8,
  parameter int pc_n        = 5,
  parameter int regcount    = 11,
  parameter int stack_depth = 4
) (
  input logic             Clock,
  input logic             nReset,
  accum_datapath_if.slave bus
);
  localparam int DW = $clog2(stack_depth + 1);

  logic [n-1:0]    r_acc;
  logic [pc_n-1:0] r_pc;
  logic            r_flag_z, r_flag_n, r_ovf, r_unf;

  logic [n-1:0]    w_imm, w_regdata, w_a, w_accin, w_wdata;
  logic [pc_n-1:0] w_pc_inc, w_target, w_pc_nxt, w_top;
  logic            w_push, w_pop, w_set_ovf, w_set_unf, w_full, w_empty;
  logic [DW-1:0]   w_depth;
  logic            w_unused_hi;

  assign w_unused_hi = &{1'b0, bus.MemData[n-1:4]};

  assign w_imm   = bus.ImmSel ? {bus.MemData[3:0], {(n-4){1'b0}}}
                              : {{(n-4){1'b0}}, bus.MemData[3:0]};
  assign w_a     = bus.Op1Sel ? w_imm : w_regdata;
  assign w_wdata = bus.WDataSel ? bus.Switches : r_acc;

  registers #(.n(n), .regcount(regcount)) u_regs (
    .Clock(Clock), .We(bus.RegWe), .Addr(bus.MemData[3:0]),
    .WData(w_wdata), .RData(w_regdata)
  );

  alu #(.n(n)) u_alu (.AluOp(bus.AluOp), .a(w_a), .b(r_acc), .y(w_accin));

  return_stack #(.pc_n(pc_n), .stack_depth(stack_depth)) u_stack (
    .Clock(Clock), .nReset(nReset), .Push(w_push), .Pop(w_pop),
    .PushData(w_pc_inc), .Top(w_top), .Full(w_full), .Empty(w_empty),
    .Depth(w_depth)
  );

  assign w_pc_inc = r_pc + pc_n'(1);
  assign w_target = w_accin[pc_n-1:0];

  // Branches test the registered flags, so a same-edge FlagWe never affects them.
  always_comb begin
    w_pc_nxt  = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    if (bus.PcWe) begin
      case (bus.PcSel)
        PcJmp: w_pc_nxt = w_target;
        PcBrz: w_pc_nxt = r_flag_z ? w_target : w_pc_inc;
        PcBrn: w_pc_nxt = r_flag_n ? w_target : w_pc_inc;
        PcCall:
          if (!w_full) begin
            w_push   = 1'b1;
            w_pc_nxt = w_target;
          end else begin
            w_set_ovf = 1'b1;
            w_pc_nxt  = w_pc_inc;
          end
        PcRet:
          if (!w_empty) begin
            w_pop    = 1'b1;
            w_pc_nxt = w_top;
          end else begin
            w_set_unf = 1'b1;
            w_pc_nxt  = w_pc_inc;
          end
        default: w_pc_nxt = w_pc_inc;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      r_pc     <= '0;
      r_acc    <= '0;
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      if (bus.AccStore) r_acc <= w_accin;
      if (bus.FlagWe) begin
        r_flag_z <= (w_accin == '0);
        r_flag_n <= w_accin[n-1];
      end
      if (w_set_ovf) r_ovf <= 1'b1;
      if (w_set_unf) r_unf <= 1'b1;
    end

  assign bus.Pc         = r_pc;
  assign bus.LEDs       = r_acc;
  assign bus.FlagZ      = r_flag_z;
  assign bus.FlagN      = r_flag_n;
  assign bus.StackDepth = w_depth;
  assign bus.StackOvf   = r_ovf;
  assign bus.StackUnf   = r_unf;
endmodule

// File: tb/tb_accum_datapath.sv
// Directed bench for accum_datapath: PC wrap, flags/branches, call/return stack,
// register file, PcWe hold, and asynchronous reset.
module tb_accum_datapath;
  import opcodes::*;
  localparam int N = 8, PCN = 5, RC = 11, SD = 4;

  logic Clock = 1'b0;
  logic nReset = 1'b0;
  int n_checks = 0;
  int n_errors = 0;

  accum_datapath_if #(.n(N), .pc_n(PCN), .stack_depth(SD)) bus ();

  accum_datapath #(.n(N), .pc_n(PCN), .regcount(RC), .stack_depth(SD)) dut (
    .Clock(Clock), .nReset(nReset), .bus(bus)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.MemData  = '0;
    bus.Switches = '0;
    bus.RegWe    = 1'b0;
    bus.ImmSel   = 1'b0;
    bus.WDataSel = 1'b0;
    bus.AccStore = 1'b0;
    bus.Op1Sel   = 1'b0;
    bus.PcWe     = 1'b0;
    bus.FlagWe   = 1'b0;
    bus.AluOp    = AluPassA;
    bus.PcSel    = PcInc;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Make AccIn an immediate: hi=1 puts the nibble in the top bits.
  task automatic set_accin(input logic [3:0] v, input logic hi);
    bus.MemData = {4'h0, v};
    bus.ImmSel  = hi;
    bus.Op1Sel  = 1'b1;
    bus.AluOp   = AluPassA;
  endtask

  task automatic pc_step(input PcSel_t s, input logic [3:0] tgt);
    idle();
    set_accin(tgt, 1'b0);
    bus.PcWe  = 1'b1;
    bus.PcSel = s;
    tick();
  endtask

  logic [4:0] call_tgt [4] = '{5'h08, 5'h09, 5'h0A, 5'h0B};
  logic [4:0] ret_pc   [4] = '{5'h0B, 5'h0A, 5'h09, 5'h06};

  initial begin
    idle();
    repeat (2) tick();
    chk("rst_pc", bus.Pc, 0);
    chk("rst_leds", bus.LEDs, 0);
    chk("rst_flagz", bus.FlagZ, 0);
    chk("rst_flagn", bus.FlagN, 0);
    chk("rst_depth", bus.StackDepth, 0);
    chk("rst_ovf", bus.StackOvf, 0);
    chk("rst_unf", bus.StackUnf, 0);
    nReset = 1'b1;

    // 32 increments: 1..31 then wrap to 0
    for (int i = 1; i <= 32; i++) begin
      pc_step(PcInc, 4'h0);
      chk("pc_inc", bus.Pc, i % 32);
    end

    // Load 0x3 into high nibble -> 0x30
    idle(); set_accin(4'h3, 1'b1); bus.AccStore = 1'b1; tick();
    chk("ld_leds", bus.LEDs, 8'h30);
    chk("ld_pc_hold", bus.Pc, 0);
    // Subtract 0x30 with FlagWe -> 0, Z=1
    idle(); set_accin(4'h3, 1'b1); bus.AluOp = AluSub; bus.AccStore = 1'b1;
    bus.FlagWe = 1'b1; tick();
    chk("sub_leds", bus.LEDs, 0);
    chk("sub_flagz", bus.FlagZ, 1);
    chk("sub_flagn", bus.FlagN, 0);
    // Brz taken using pre-edge Z while FlagWe rewrites Z from AccIn=0x0C
    idle(); set_accin(4'hC, 1'b0); bus.PcWe = 1'b1; bus.PcSel = PcBrz;
    bus.FlagWe = 1'b1; tick();
    chk("brz_taken", bus.Pc, 5'h0C);
    chk("brz_newz", bus.FlagZ, 0);
    pc_step(PcBrz, 4'hC);
    chk("brz_not_taken", bus.Pc, 5'h0D);
    // 0x80 sets N, then Brn taken to 3
    idle(); set_accin(4'h8, 1'b1); bus.AccStore = 1'b1; bus.FlagWe = 1'b1; tick();
    chk("n_leds", bus.LEDs, 8'h80);
    chk("n_flagn", bus.FlagN, 1);
    chk("n_pc_hold", bus.Pc, 5'h0D);
    pc_step(PcBrn, 4'h3);
    chk("brn_taken", bus.Pc, 5'h03);
    chk("brn_leds_hold", bus.LEDs, 8'h80);
    pc_step(PcJmp, 4'h4);
    chk("jmp", bus.Pc, 5'h04);

    // Call 0x10 at Pc=4 with AccStore, then return to 5
    idle(); set_accin(4'h1, 1'b1); bus.PcWe = 1'b1; bus.PcSel = PcCall;
    bus.AccStore = 1'b1; tick();
    chk("call_pc", bus.Pc, 5'h10);
    chk("call_leds", bus.LEDs, 8'h10);
    chk("call_depth", bus.StackDepth, 1);
    pc_step(PcRet, 4'h0);
    chk("ret_pc", bus.Pc, 5'h05);
    chk("ret_depth", bus.StackDepth, 0);

    // Register file: switches -> r2, read back; Acc -> r5, then 1 + r5
    idle(); bus.MemData = 8'h02; bus.Switches = 8'hA5; bus.WDataSel = 1'b1;
    bus.RegWe = 1'b1; tick();
    idle(); bus.MemData = 8'h02; bus.AccStore = 1'b1; tick();
    chk("rf_sw", bus.LEDs, 8'hA5);
    idle(); bus.MemData = 8'h05; bus.RegWe = 1'b1; tick();
    idle(); set_accin(4'h1, 1'b0); bus.AccStore = 1'b1; tick();
    chk("rf_imm", bus.LEDs, 8'h01);
    idle(); bus.MemData = 8'h05; bus.AluOp = AluAdd; bus.AccStore = 1'b1; tick();
    chk("rf_add", bus.LEDs, 8'hA6);
    chk("rf_pc_hold", bus.Pc, 5'h05);

    // Nested calls from Pc=5, fifth overflows
    for (int i = 0; i < 4; i++) begin
      pc_step(PcCall, call_tgt[i][3:0]);
      chk("nest_pc", bus.Pc, call_tgt[i]);
      chk("nest_depth", bus.StackDepth, i + 1);
    end
    pc_step(PcCall, 4'hF);
    chk("ovf_pc", bus.Pc, 5'h0C);
    chk("ovf_flag", bus.StackOvf, 1);
    chk("ovf_depth", bus.StackDepth, 4);
    for (int i = 0; i < 4; i++) begin
      pc_step(PcRet, 4'h0);
      chk("unwind_pc", bus.Pc, ret_pc[i]);
      chk("unwind_depth", bus.StackDepth, 3 - i);
    end
    chk("ovf_sticky", bus.StackOvf, 1);

    // PcWe=0 holds everything for all eight PcSel encodings
    pc_step(PcCall, 4'hE);
    chk("hold_setup_pc", bus.Pc, 5'h0E);
    for (int s = 0; s < 8; s++) begin
      idle(); set_accin(4'h3, 1'b0); bus.PcSel = PcSel_t'(3'(s)); tick();
      chk("hold_pc", bus.Pc, 5'h0E);
      chk("hold_depth", bus.StackDepth, 1);
      chk("hold_ovf", bus.StackOvf, 1);
      chk("hold_unf", bus.StackUnf, 0);
    end
    pc_step(PcRet, 4'h0);
    chk("hold_ret_pc", bus.Pc, 5'h07);

    // Return on empty stack
    pc_step(PcRet, 4'h0);
    chk("unf_pc", bus.Pc, 5'h08);
    chk("unf_flag", bus.StackUnf, 1);
    chk("unf_depth", bus.StackDepth, 0);
    pc_step(PcInc, 4'h0);
    chk("unf_sticky", bus.StackUnf, 1);
    chk("unf_inc_pc", bus.Pc, 5'h09);
    idle(); bus.PcWe = 1'b1; bus.PcSel = PcSel_t'(3'd6); tick();
    chk("undef6_pc", bus.Pc, 5'h0A);
    idle(); bus.PcWe = 1'b1; bus.PcSel = PcSel_t'(3'd7); tick();
    chk("undef7_pc", bus.Pc, 5'h0B);

    // Asynchronous reset mid-sequence with a live stack entry
    pc_step(PcCall, 4'h5);
    chk("pre_rst_depth", bus.StackDepth, 1);
    idle();
    nReset = 1'b0;
    #2;
    chk("arst_pc", bus.Pc, 0);
    chk("arst_leds", bus.LEDs, 0);
    chk("arst_depth", bus.StackDepth, 0);
    chk("arst_ovf", bus.StackOvf, 0);
    chk("arst_unf", bus.StackUnf, 0);
    chk("arst_flagn", bus.FlagN, 0);
    tick();
    nReset = 1'b1;
    pc_step(PcInc, 4'h0);
    chk("post_rst_pc", bus.Pc, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
